// File: rtl/btn_pkg.sv
// Shared definitions for the push-button reader.
// Holds FSM encodings, default parameters and a width helper.
package btn_pkg;

    localparam int TICK_DIV_DEF   = 12000;
    localparam int DB_TICKS_DEF   = 20;
    localparam int LONG_TICKS_DEF = 1000;
    localparam int NUM_BTN        = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    // Counter width able to hold 0..n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: synchronizer, tick-based debounce and
// press/short/long classification FSM.
module btn_chan
    import btn_pkg::*;
#(
    parameter int DB_TICKS   = DB_TICKS_DEF,
    parameter int LONG_TICKS = LONG_TICKS_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic press,
    output logic short_pulse,
    output logic long_pulse
);

    localparam int DW = cnt_w(DB_TICKS + 1);
    localparam int HW = cnt_w(LONG_TICKS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_TICKS - 1);
    localparam logic [HW-1:0] HL_LAST = HW'(LONG_TICKS - 1);

    logic          s1;
    logic          s2;
    logic [DW-1:0] db_cnt;
    logic          flip;
    logic          rise;
    logic          fall;

    btn_state_t    state;
    btn_state_t    state_nxt;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nxt;
    logic          press_nxt;
    logic          short_nxt;
    logic          long_nxt;

    // Level changes on the tick the disagreement run hits DB_TICKS.
    assign flip = tick && (s2 != level) && (db_cnt == DB_LAST);
    assign rise = flip && !level;
    assign fall = flip && level;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Count consecutive disagreeing ticks; flip level when enough.
    always_ff @(posedge CLK) begin
        if (RST) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (tick) begin
            if (s2 == level) begin
                db_cnt <= '0;
            end else if (flip) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Press classification state and registered pulse outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            hold        <= '0;
            press       <= 1'b0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold        <= hold_nxt;
            press       <= press_nxt;
            short_pulse <= short_nxt;
            long_pulse  <= long_nxt;
        end
    end

    // Next state; a release wins over reaching the long threshold.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        press_nxt = 1'b0;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                    hold_nxt  = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end else if (tick) begin
                    hold_nxt = hold + 1'b1;
                    if (hold == HL_LAST) begin
                        state_nxt = HELD;
                        long_nxt  = 1'b1;
                    end
                end
            end
            HELD: begin
                if (fall) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/btn_reader.sv
// Four-button reader: shared debounce tick prescaler feeding
// four independent button channels.
module btn_reader
    import btn_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int DB_TICKS   = DB_TICKS_DEF,
    parameter int LONG_TICKS = LONG_TICKS_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_BTN-1:0]  BTN,
    output logic [NUM_BTN-1:0]  BTN_LEVEL,
    output logic [NUM_BTN-1:0]  PRESS,
    output logic [NUM_BTN-1:0]  SHORT,
    output logic [NUM_BTN-1:0]  LONG
);

    localparam int PW = cnt_w(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == P_LAST);

    // Free-running prescaler; tick marks its last count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_chan #(
            .DB_TICKS   (DB_TICKS),
            .LONG_TICKS (LONG_TICKS)
        ) u_chan (
            .CLK         (CLK),
            .RST         (RST),
            .tick        (tick),
            .btn         (BTN[i]),
            .level       (BTN_LEVEL[i]),
            .press       (PRESS[i]),
            .short_pulse (SHORT[i]),
            .long_pulse  (LONG[i])
        );
    end

endmodule

// File: tb/tb_btn_reader.sv
// Bench for btn_reader: directed scenarios plus random stimulus,
// checked every cycle against a behavioural model.
module tb_btn_reader;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int LT = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'h0;
    logic [3:0] btn_level;
    logic [3:0] press;
    logic [3:0] short_o;
    logic [3:0] long_o;

    btn_reader #(
        .TICK_DIV   (TD),
        .DB_TICKS   (DB),
        .LONG_TICKS (LT)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .BTN       (btn),
        .BTN_LEVEL (btn_level),
        .PRESS     (press),
        .SHORT     (short_o),
        .LONG      (long_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;

    // behavioural model state
    int         m_phase;
    logic [3:0] m_d1, m_d2, m_lvl, m_pr, m_sh, m_lg;
    logic [3:0] m_active, m_long_done;
    int         m_run[4];
    int         m_hold[4];

    // observation records
    int         press_cnt[4], short_cnt[4], long_cnt[4], lvl_chg[4];
    int         rise_cyc[4], long_cyc[4], press_cyc[4], short_cyc[4];
    int         all_press_cyc;
    logic [3:0] prev_lvl = 4'h0;

    task automatic model_step();
        logic tk;
        logic sv;
        logic chg;
        m_pr = 4'h0;
        m_sh = 4'h0;
        m_lg = 4'h0;
        if (rst) begin
            m_phase = 0;
            m_d1 = 4'h0; m_d2 = 4'h0; m_lvl = 4'h0;
            m_active = 4'h0; m_long_done = 4'h0;
            for (int c = 0; c < 4; c++) begin
                m_run[c] = 0;
                m_hold[c] = 0;
            end
        end else begin
            tk = (m_phase == TD - 1);
            m_phase = (m_phase + 1) % TD;
            for (int c = 0; c < 4; c++) begin
                sv = m_d2[c];
                m_d2[c] = m_d1[c];
                m_d1[c] = btn[c];
                chg = 1'b0;
                if (tk) begin
                    if (sv != m_lvl[c]) begin
                        m_run[c]++;
                        if (m_run[c] == DB) begin
                            m_lvl[c] = ~m_lvl[c];
                            m_run[c] = 0;
                            chg = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                if (chg && m_lvl[c]) begin
                    m_pr[c] = 1'b1;
                    m_active[c] = 1'b1;
                    m_long_done[c] = 1'b0;
                    m_hold[c] = 0;
                end else if (chg) begin
                    if (m_active[c] && !m_long_done[c]) m_sh[c] = 1'b1;
                    m_active[c] = 1'b0;
                    m_long_done[c] = 1'b0;
                end else if (tk && m_active[c] && !m_long_done[c]) begin
                    m_hold[c]++;
                    if (m_hold[c] == LT) begin
                        m_lg[c] = 1'b1;
                        m_long_done[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic clr();
        for (int c = 0; c < 4; c++) begin
            press_cnt[c] = 0; short_cnt[c] = 0;
            long_cnt[c] = 0;  lvl_chg[c] = 0;
            rise_cyc[c] = -1; long_cyc[c] = -1;
            press_cyc[c] = -1; short_cyc[c] = -1;
        end
        all_press_cyc = -1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs,
                           input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d",
                   tag, obs, lo, hi);
        end
    endtask

    // one clock: model update, output compare, observation tally
    task automatic cyc();
        logic [15:0] obs;
        logic [15:0] exp;
        @(posedge clk);
        model_step();
        #1;
        cycle++;
        obs = {btn_level, press, short_o, long_o};
        exp = {m_lvl, m_pr, m_sh, m_lg};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL cyc%0d outputs observed=%h expected=%h",
                   cycle, obs, exp);
        end
        for (int c = 0; c < 4; c++) begin
            if (press[c]) begin
                press_cnt[c]++;
                if (press_cyc[c] < 0) press_cyc[c] = cycle;
            end
            if (short_o[c]) begin
                short_cnt[c]++;
                if (short_cyc[c] < 0) short_cyc[c] = cycle;
            end
            if (long_o[c]) begin
                long_cnt[c]++;
                if (long_cyc[c] < 0) long_cyc[c] = cycle;
            end
            if (btn_level[c] !== prev_lvl[c]) begin
                lvl_chg[c]++;
                if (btn_level[c] && rise_cyc[c] < 0) rise_cyc[c] = cycle;
            end
        end
        if (press === 4'hf && all_press_cyc < 0) all_press_cyc = cycle;
        prev_lvl = btn_level;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int t0;
        int t1;
        int len;

        clr();
        @(negedge clk);
        rst = 1'b1;
        run(3);
        chk("reset_outputs", int'({btn_level, press, short_o, long_o}), 0);
        rst = 1'b0;
        run(5);

        // short press on channel 0
        clr();
        t0 = cycle;
        btn = 4'b0001;
        run(6 * TD);
        btn = 4'b0000;
        run(30);
        chk_rng("s1_rise_delay", rise_cyc[0] - t0, 11, 16);
        chk("s1_press", press_cnt[0], 1);
        chk("s1_short", short_cnt[0], 1);
        chk("s1_long", long_cnt[0], 0);
        chk("s1_short_after_release", int'(short_cyc[0] > t0 + 6 * TD), 1);

        // 2-tick glitch on channel 1
        clr();
        btn = 4'b0010;
        run(2 * TD);
        btn = 4'b0000;
        run(30);
        chk("s2_level_chg", lvl_chg[1], 0);
        chk("s2_pulses", press_cnt[1] + short_cnt[1] + long_cnt[1], 0);

        // long hold on channel 2
        clr();
        btn = 4'b0100;
        run(20 * TD);
        btn = 4'b0000;
        run(30);
        chk("s3_press", press_cnt[2], 1);
        chk("s3_long_delay", long_cyc[2] - rise_cyc[2], LT * TD);
        chk("s3_long_once", long_cnt[2], 1);
        chk("s3_no_short", short_cnt[2], 0);

        // all four pressed together
        clr();
        btn = 4'b1111;
        run(30);
        btn = 4'b0000;
        run(30);
        chk("s4_same_cycle", int'(all_press_cyc > 0), 1);
        for (int c = 0; c < 4; c++) begin
            chk("s4_press_count", press_cnt[c], 1);
            chk("s4_short_count", short_cnt[c], 1);
        end

        // reset in the middle of a channel 3 hold
        clr();
        btn = 4'b1000;
        run(5 * TD);
        rst = 1'b1;
        run(1);
        chk("s5_reset_out", int'({btn_level, press, short_o, long_o}), 0);
        rst = 1'b0;
        press_cyc[3] = -1;
        t0 = cycle;
        run(30);
        t1 = cycle;
        btn = 4'b0000;
        run(30);
        chk_rng("s5_fresh_press", press_cyc[3] - t0, 11, 16);
        chk("s5_press_total", press_cnt[3], 2);
        chk("s5_short_total", short_cnt[3], 1);
        chk("s5_short_late", int'(short_cyc[3] > t1), 1);
        chk("s5_long", long_cnt[3], 0);

        // channel 0 toggling every tick
        clr();
        for (int i = 0; i < 20; i++) begin
            btn = {3'b000, ~btn[0]};
            run(TD);
        end
        btn = 4'b0000;
        run(20);
        chk("s6_level_chg", lvl_chg[0], 0);

        // random stimulus, checked by the model every cycle
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                run(1);
                rst = 1'b0;
            end
            btn = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 70);
            run(len);
        end
        btn = 4'b0000;
        run(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_reader.md
BTN_READER -- requirements
Module: btn_reader

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12000, meaning CLK cycles per debounce tick (1 ms at 12 MHz).
REQ-002 SHALL have parameter DB_TICKS, default 20, meaning consecutive ticks of disagreement needed to change a debounced level.
REQ-003 SHALL have parameter LONG_TICKS, default 1000, meaning ticks of held level that make a press long.
REQ-004 SHALL have port CLK  input  1  system clock; all logic on posedge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port BTN  input  4  raw asynchronous push buttons, active-high.
REQ-007 SHALL have port BTN_LEVEL  output  4  debounced button level.
REQ-008 SHALL have port PRESS  output  4  one-CLK pulse on a debounced 0->1 change.
REQ-009 SHALL have port SHORT  output  4  one-CLK pulse on release of a press shorter than LONG_TICKS.
REQ-010 SHALL have port LONG  output  4  one-CLK pulse when a hold reaches LONG_TICKS, once per press.

Function
REQ-011 SHALL pass each BTN bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL use one shared prescaler counting 0..TICK_DIV-1 that wraps to 0 and asserts tick for one CLK when at TICK_DIV-1.
REQ-013 SHALL, per channel on each tick, increment the debounce count while the synced input differs from BTN_LEVEL, and clear it when they agree.
REQ-014 SHALL invert BTN_LEVEL and clear the debounce count on the tick where the count reaches DB_TICKS; a glitch shorter than DB_TICKS ticks SHALL never change BTN_LEVEL.
REQ-015 SHALL implement a per-channel FSM with states IDLE, PRESSED, HELD; reset state IDLE.
REQ-016 SHALL move IDLE->PRESSED on a debounced rise, pulse PRESS in the same cycle as the BTN_LEVEL change, and clear the hold count.
REQ-017 SHALL increment the hold count on each tick in PRESSED; the tick where it reaches LONG_TICKS moves PRESSED->HELD and pulses LONG.
REQ-018 SHALL move PRESSED->IDLE on a debounced fall with a SHORT pulse, and HELD->IDLE on a debounced fall with no pulse.
REQ-019 SHALL give the release priority when the debounced fall and LONG_TICKS are reached in the same cycle: SHORT pulses and LONG does not.
REQ-020 SHALL keep the hold count saturated in HELD with no further LONG pulses, however long the hold.
REQ-021 SHALL run all four channels independently; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.
REQ-022 SHALL size the counters from the parameters (clog2 width of each limit) with no wrap inside the valid range.
REQ-023 SHALL have a latency from a stable BTN change to the PRESS/SHORT pulse of 2 sync cycles plus DB_TICKS ticks, with prescaler phase jitter up to 1 tick.

Reset
REQ-024 SHALL, while RST is high, clear the synchronizers, prescaler, debounce and hold counts, BTN_LEVEL, PRESS, SHORT and LONG to 0, and set every FSM to IDLE.
REQ-025 SHALL, when RST is asserted mid-press, emit no SHORT/LONG pulse for that press; a button still held after RST falls SHALL debounce and then produce a fresh PRESS.

Structure
REQ-026 SHALL place the FSM state encodings (IDLE=0, PRESSED=1, HELD=2) and the default parameter values in shared package btn_pkg.
REQ-027 SHALL implement the per-button synchronizer, debounce and FSM as sub-module btn_chan, instantiated 4 times, with the prescaler tick shared by all instances.

Verification
Bench parameters for all scenarios: TICK_DIV=4, DB_TICKS=3, LONG_TICKS=10.
REQ-028 SHALL cover: BTN=0001 held 6 ticks then 0 -> BTN_LEVEL[0] rises 3 to 4 ticks after the edge, one PRESS[0] pulse, then one SHORT[0] pulse after release, no LONG.
REQ-029 SHALL cover: BTN[1] pulsed high for 2 ticks -> BTN_LEVEL, PRESS, SHORT and LONG all stay 0.
REQ-030 SHALL cover: BTN[2] held 20 ticks -> PRESS[2], then LONG[2] exactly 10 ticks after BTN_LEVEL[2] rises, no second LONG, and no SHORT on release.
REQ-031 SHALL cover: BTN=1111 asserted in the same cycle -> four PRESS bits pulse in the same CLK cycle.
REQ-032 SHALL cover: RST pulsed for 1 CLK 5 ticks into a BTN[3] hold -> all outputs 0, then a fresh PRESS[3] 3 to 4 ticks later, with no SHORT or LONG from the aborted press.
REQ-033 SHALL cover: BTN[0] toggling every tick for 20 ticks -> BTN_LEVEL[0] never changes.
